// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, sequencer states and width default.
package alu_pkg;

    localparam int unsigned DataWDefault = 32;

    // Operation encoding shared with the ALUController.
    typedef enum logic [3:0] {
        OpAnd   = 4'b0000,
        OpOr    = 4'b0001,
        OpAdd   = 4'b0010,
        OpSub   = 4'b0011,
        OpXor   = 4'b0100,
        OpSll   = 4'b0101,
        OpSrl   = 4'b0110,
        OpSra   = 4'b0111,
        OpSlt   = 4'b1000,
        OpSltu  = 4'b1001,
        OpBeq   = 4'b1010,
        OpBne   = 4'b1011,
        OpBlt   = 4'b1100,
        OpBge   = 4'b1101,
        OpPassb = 4'b1110,
        OpRsvd  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } alu_state_e;

    // Shifts are the only ops that are sequenced over several cycles.
    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU operations and branch compare.
// Shift ops return src_a here, which is the correct result for a zero shift amount;
// nonzero shifts are sequenced by alu_exec_unit.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    // Shared comparators for set-less-than and branch ops.
    always_comb begin
        eq   = (src_a == src_b);
        lt_s = ($signed(src_a) < $signed(src_b));
        lt_u = (src_a < src_b);
    end

    // Operation decode; compare ops produce a zero-extended condition bit.
    always_comb begin
        result       = '0;
        branch_taken = 1'b0;
        case (op)
            OpAnd:   result = src_a & src_b;
            OpOr:    result = src_a | src_b;
            OpAdd:   result = src_a + src_b;
            OpSub:   result = src_a - src_b;
            OpXor:   result = src_a ^ src_b;
            OpSll,
            OpSrl,
            OpSra:   result = src_a;
            OpSlt:   result = DATA_W'(lt_s);
            OpSltu:  result = DATA_W'(lt_u);
            OpBeq: begin
                result       = DATA_W'(eq);
                branch_taken = eq;
            end
            OpBne: begin
                result       = DATA_W'(!eq);
                branch_taken = !eq;
            end
            OpBlt: begin
                result       = DATA_W'(lt_s);
                branch_taken = lt_s;
            end
            OpBge: begin
                result       = DATA_W'(!lt_s);
                branch_taken = !lt_s;
            end
            OpPassb: result = src_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshake, bit-serial shift sequencing and
// registered result/flag outputs around alu_comb_core.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic              busy
);

    localparam int unsigned ShW = $clog2(DATA_W);

    alu_state_e        state;
    logic [ShW-1:0]    count;
    logic [DATA_W-1:0] shift_data;
    alu_op_e           shift_op;

    logic [DATA_W-1:0] core_result;
    logic              core_branch;
    logic              accept;
    logic [ShW-1:0]    shamt;
    logic [DATA_W-1:0] shift_next;

    alu_comb_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .result      (core_result),
        .branch_taken(core_branch)
    );

    // Handshake: accept from IDLE, or from DONE when the result leaves the same edge.
    always_comb begin
        in_ready = !reset && !flush &&
                   ((state == StIdle) || ((state == StDone) && out_ready));
        accept   = in_valid && in_ready;
        shamt    = src_b[ShW-1:0];
        busy     = (state != StIdle);
    end

    // One-bit step of the shift currently in flight.
    always_comb begin
        case (shift_op)
            OpSll:   shift_next = {shift_data[DATA_W-2:0], 1'b0};
            OpSrl:   shift_next = {1'b0, shift_data[DATA_W-1:1]};
            OpSra:   shift_next = {shift_data[DATA_W-1], shift_data[DATA_W-1:1]};
            default: shift_next = shift_data;
        endcase
    end

    // Sequencer FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b1;
            branch_taken <= 1'b0;
            count        <= '0;
            shift_data   <= '0;
            shift_op     <= OpSll;
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            if (is_shift_op(op) && (shamt != '0)) begin
                state      <= StShift;
                out_valid  <= 1'b0;
                count      <= shamt;
                shift_data <= src_a;
                shift_op   <= op;
            end else begin
                state        <= StDone;
                out_valid    <= 1'b1;
                result       <= core_result;
                zero         <= (core_result == '0);
                branch_taken <= core_branch;
            end
        end else begin
            case (state)
                StShift: begin
                    shift_data <= shift_next;
                    count      <= count - ShW'(1);
                    // Last step lands the shifted value straight into the result.
                    if (count == ShW'(1)) begin
                        state        <= StDone;
                        out_valid    <= 1'b1;
                        result       <= shift_next;
                        zero         <= (shift_next == '0);
                        branch_taken <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes expected results at acceptance,
// an independent monitor pops and compares on every output transfer.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        br;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    alu_op_e     op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(
        .DATA_W(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .branch_taken(branch_taken),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Present a request until accepted; optionally record the expected response.
    task automatic send(input alu_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic br, input bit expect_out,
                        output int waited);
        exp_t e;
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (expect_out) begin
                e.r  = r;
                e.z  = (r == 32'h0);
                e.br = br;
                exp_q.push_back(e);
            end
            #1;
            in_valid = 1'b0;
            op       = OpRsvd;
            src_a    = ~a;
            src_b    = ~b;
        end
    endtask

    // Count cycles from acceptance until out_valid rises and check the latency.
    task automatic wait_valid(input string name, input int lat);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n), 32'(lat));
    endtask

    task automatic run_vec(input string name, input alu_op_e o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic br,
                           input int lat);
        int w;
        send(o, a, b, r, br, 1'b1, w);
        wait_valid(name, lat);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: output 0x%08h presented, required none",
                             result);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_result", result, e.r);
                    chk("mon_zero", 32'(zero), 32'(e.z));
                    chk("mon_branch", 32'(branch_taken), 32'(e.br));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = OpAnd;
        src_a     = '0;
        src_b     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_branch", 32'(branch_taken), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        run_vec("add_ovf_lat", OpAdd, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_vec("sub_zero_lat", OpSub, 32'h5, 32'h5, 32'h0, 1'b0, 1);
        run_vec("add_wrap", OpAdd, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0, 1);
        run_vec("and", OpAnd, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
        run_vec("or", OpOr, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
        run_vec("xor", OpXor, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
        run_vec("sll_shamt0", OpSll, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1);
        run_vec("sll_upper_ign", OpSll, 32'h1, 32'hFFFF_FFE1, 32'h2, 1'b0, 2);
        run_vec("srl_3", OpSrl, 32'h8000_0001, 32'h3, 32'h1000_0000, 1'b0, 4);
        run_vec("sra_31", OpSra, 32'hC000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 32);
        run_vec("slt_neg", OpSlt, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
        run_vec("slt_false", OpSlt, 32'h5, 32'h3, 32'h0, 1'b0, 1);
        run_vec("sltu_true", OpSltu, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1);
        run_vec("beq_eq", OpBeq, 32'h55, 32'h55, 32'h1, 1'b1, 1);
        run_vec("bne_eq", OpBne, 32'h55, 32'h55, 32'h0, 1'b0, 1);
        run_vec("bge_false", OpBge, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        run_vec("bge_equal", OpBge, 32'h1, 32'h1, 32'h1, 1'b1, 1);
        run_vec("passb", OpPassb, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1);
        run_vec("reserved", OpRsvd, 32'h1234, 32'h5678, 32'h0, 1'b0, 1);

        // SRA by 4: in_ready low through four shift cycles, result on the fifth.
        send(OpSra, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b1, w);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("sra_in_ready_low", 32'(in_ready), 0);
            chk("sra_not_valid", 32'(out_valid), 0);
        end
        @(negedge clk);
        chk("sra_valid_at_5", 32'(out_valid), 1);
        @(posedge clk);
        #1;

        // Back-pressure on a BLT result, then back-to-back handoff to an ADD.
        out_ready = 1'b0;
        send(OpBlt, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_result", result, 32'h1);
            chk("hold_branch", 32'(branch_taken), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(OpAdd, 32'h3, 32'h4, 32'h7, 1'b0, 1'b1, w);
        chk("b2b_no_wait", 32'(w), 0);
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;

        // Flush in the second cycle of a 10-bit SLL; a request during flush is dropped.
        send(OpSll, 32'h1, 32'd10, 32'h0, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = OpAdd;
        src_a    = 32'h1;
        src_b    = 32'h1;
        @(negedge clk);
        chk("flush_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle", 32'(busy), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 32'(seen), 0);
        @(posedge clk);
        #1;

        // Flush in IDLE with a request present: nothing is accepted.
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = OpPassb;
        src_b    = 32'h99;
        @(negedge clk);
        chk("idle_flush_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_valid", 32'(out_valid), 0);
        chk("idle_flush_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        // Reset while DONE holds 0x1234: the result is discarded.
        out_ready = 1'b0;
        send(OpAdd, 32'h1000, 32'h234, 32'h1234, 1'b0, 1'b1, w);
        @(negedge clk);
        chk("done_hold_1234", result, 32'h1234);
        chk("done_hold_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", 32'(zero), 1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready_up", 32'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        run_vec("sltu_after_rst", OpSltu, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
